spike_aer_encoder: RTL and testbench

- Downstream consumer of a bank of lif_neuron instances.
- Collects the per-neuron spike_out pulses into a pending bitmap and serialises them with a round-robin arbiter.
- Writes Address-Event Representation (AER) events, each a neuron ID plus a timestep stamp, into a small first-word-fall-through (FWFT) FIFO.
- Presents the events on a valid/ready stream to the spike router / AXI output path.

---
 rtl/snn_aer_pkg.sv | 26 ++
 rtl/rr_arbiter.sv | 58 +++++
 rtl/spike_aer_encoder.sv | 147 ++++++++++++++
 tb/tb_spike_aer_encoder.sv | 372 +++++++++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/snn_aer_pkg.sv
// Shared AER event widths, stats constants and helpers for the spike encoder path.
package snn_aer_pkg;

    // AER event fields; these must match the spike router's decode.
    localparam int unsigned AER_NEURON_ID_WIDTH = 4;
    localparam int unsigned AER_TIMESTAMP_WIDTH = 16;

    // Width of the saturating dropped-spike counter.
    localparam int unsigned DROPPED_CNT_WIDTH = 16;

    // Widest vector the popcount helper accepts; callers zero-extend into it.
    localparam int unsigned POPCOUNT_MAX_WIDTH = 64;

    // Number of set bits in v.
    function automatic int unsigned popcount(input logic [POPCOUNT_MAX_WIDTH-1:0] v);
        int unsigned n;
        n = 0;
        for (int unsigned i = 0; i < POPCOUNT_MAX_WIDTH; i++) begin
            if (v[i]) begin
                n = n + 1;
            end
        end
        return n;
    endfunction

endpackage : snn_aer_pkg

// File: rtl/rr_arbiter.sv
// Round-robin arbiter: one-hot grant over req, searching upward from an
// internal pointer that moves to just past the last winner.
module rr_arbiter #(
    parameter int unsigned WIDTH = 16,
    parameter int unsigned IDX_W = (WIDTH > 1) ? $clog2(WIDTH) : 1
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic [WIDTH-1:0] req,
    output logic [WIDTH-1:0] grant_c,
    output logic [IDX_W-1:0] grant_idx_c,
    output logic             grant_valid_c
);

    logic [IDX_W-1:0] ptr_q;
    logic [IDX_W-1:0] ptr_next_c;
    int unsigned      cand;

    // First requester at or after the pointer, wrapping around the vector.
    always_comb begin
        grant_c       = '0;
        grant_idx_c   = '0;
        grant_valid_c = 1'b0;
        cand          = 0;
        for (int unsigned off = 0; off < WIDTH; off++) begin
            cand = (32'(ptr_q) + off) % WIDTH;
            if (!grant_valid_c && req[IDX_W'(cand)]) begin
                grant_valid_c = 1'b1;
                grant_idx_c   = IDX_W'(cand);
            end
        end
        if (grant_valid_c) begin
            grant_c[grant_idx_c] = 1'b1;
        end
    end

    // Pointer moves to the slot after the winner, modulo WIDTH.
    always_comb begin
        ptr_next_c = ptr_q;
        if (grant_valid_c) begin
            if (grant_idx_c == IDX_W'(WIDTH - 1)) begin
                ptr_next_c = '0;
            end else begin
                ptr_next_c = grant_idx_c + IDX_W'(1);
            end
        end
    end

    // Pointer register; held when nothing is granted.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            ptr_q <= '0;
        end else begin
            ptr_q <= ptr_next_c;
        end
    end

endmodule : rr_arbiter

// File: rtl/spike_aer_encoder.sv
// Spike-to-AER encoder: captures neuron spike pulses into a pending bitmap,
// serialises them round-robin and queues {neuron id, timestep} events in a
// small FWFT FIFO presented on a valid/ready stream.
module spike_aer_encoder
    import snn_aer_pkg::*;
#(
    parameter int unsigned NUM_NEURONS     = 16,
    parameter int unsigned NEURON_ID_WIDTH = AER_NEURON_ID_WIDTH,
    parameter int unsigned TIMESTAMP_WIDTH = AER_TIMESTAMP_WIDTH,
    parameter int unsigned FIFO_DEPTH      = 8,
    parameter int unsigned FIFO_ADDR_WIDTH = 3
) (
    input  logic                         clk,
    input  logic                         rst_n,
    input  logic                         enable,
    input  logic [NUM_NEURONS-1:0]       spike_in,
    input  logic                         timestep_tick,
    input  logic                         clear_stats,
    output logic                         aer_valid,
    input  logic                         aer_ready,
    output logic [NEURON_ID_WIDTH-1:0]   aer_neuron_id,
    output logic [TIMESTAMP_WIDTH-1:0]   aer_timestamp,
    output logic [FIFO_ADDR_WIDTH:0]     fifo_count,
    output logic [DROPPED_CNT_WIDTH-1:0] dropped_count,
    output logic                         overflow
);

    localparam int unsigned IDX_W = (NUM_NEURONS > 1) ? $clog2(NUM_NEURONS) : 1;
    localparam int unsigned CNT_W = FIFO_ADDR_WIDTH + 1;
    localparam int unsigned SUM_W = DROPPED_CNT_WIDTH + 1;

    typedef struct packed {
        logic [NEURON_ID_WIDTH-1:0] id;
        logic [TIMESTAMP_WIDTH-1:0] ts;
    } aer_event_t;

    logic [NUM_NEURONS-1:0]     pend_q;
    logic [NUM_NEURONS-1:0]     req_c;
    logic [NUM_NEURONS-1:0]     grant_c;
    logic [NUM_NEURONS-1:0]     drop_c;
    logic [IDX_W-1:0]           grant_idx_c;
    logic                       grant_valid_c;
    logic                       fifo_full_c;
    logic                       push_c;
    logic                       pop_c;
    logic [SUM_W-1:0]           drop_sum_c;
    logic [TIMESTAMP_WIDTH-1:0] ts_q;
    logic [FIFO_ADDR_WIDTH-1:0] wr_ptr_q;
    logic [FIFO_ADDR_WIDTH-1:0] rd_ptr_q;
    aer_event_t                 wr_event_c;
    aer_event_t                 head_c;
    aer_event_t                 fifo_mem [FIFO_DEPTH];

    // Arbitration is blocked while disabled or while the FIFO is full at the
    // start of the cycle; a same-cycle pop does not open a slot.
    always_comb begin
        fifo_full_c = (fifo_count == CNT_W'(FIFO_DEPTH));
        req_c       = (enable && !fifo_full_c) ? pend_q : '0;
        drop_c      = enable ? (spike_in & pend_q & ~grant_c) : '0;
        push_c      = grant_valid_c;
        pop_c       = aer_valid && aer_ready;
        drop_sum_c  = SUM_W'(dropped_count) + SUM_W'(popcount(POPCOUNT_MAX_WIDTH'(drop_c)));
        wr_event_c  = '{id: NEURON_ID_WIDTH'(grant_idx_c), ts: ts_q};
        head_c      = fifo_mem[rd_ptr_q];
    end

    rr_arbiter #(
        .WIDTH (NUM_NEURONS),
        .IDX_W (IDX_W)
    ) u_rr_arbiter (
        .clk           (clk),
        .rst_n         (rst_n),
        .req           (req_c),
        .grant_c       (grant_c),
        .grant_idx_c   (grant_idx_c),
        .grant_valid_c (grant_valid_c)
    );

    // Pending bitmap: new spikes OR in after the granted bit is cleared, so a
    // re-spike on the granted neuron stays pending.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            pend_q <= '0;
        end else if (enable) begin
            pend_q <= (pend_q & ~grant_c) | spike_in;
        end
    end

    // Drop statistics; a clear in the same cycle as a drop takes priority.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            dropped_count <= '0;
            overflow      <= 1'b0;
        end else if (clear_stats) begin
            dropped_count <= '0;
            overflow      <= 1'b0;
        end else if (|drop_c) begin
            overflow      <= 1'b1;
            dropped_count <= drop_sum_c[DROPPED_CNT_WIDTH] ? '1 : drop_sum_c[DROPPED_CNT_WIDTH-1:0];
        end
    end

    // Timestep counter; events written this cycle carry the pre-tick value.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            ts_q <= '0;
        end else if (enable && timestep_tick) begin
            ts_q <= ts_q + TIMESTAMP_WIDTH'(1);
        end
    end

    // Event storage; contents are masked at the output until valid, so no reset.
    always_ff @(posedge clk) begin
        if (push_c) begin
            fifo_mem[wr_ptr_q] <= wr_event_c;
        end
    end

    // FIFO pointers and occupancy; pointers wrap naturally at power-of-two depth.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            wr_ptr_q   <= '0;
            rd_ptr_q   <= '0;
            fifo_count <= '0;
        end else begin
            if (push_c) begin
                wr_ptr_q <= wr_ptr_q + FIFO_ADDR_WIDTH'(1);
            end
            if (pop_c) begin
                rd_ptr_q <= rd_ptr_q + FIFO_ADDR_WIDTH'(1);
            end
            case ({push_c, pop_c})
                2'b10:   fifo_count <= fifo_count + CNT_W'(1);
                2'b01:   fifo_count <= fifo_count - CNT_W'(1);
                default: fifo_count <= fifo_count;
            endcase
        end
    end

    // FWFT head: valid whenever occupied, fields zero when empty.
    always_comb begin
        aer_valid     = (fifo_count != '0);
        aer_neuron_id = aer_valid ? head_c.id : '0;
        aer_timestamp = aer_valid ? head_c.ts : '0;
    end

endmodule : spike_aer_encoder

// File: tb/tb_spike_aer_encoder.sv
// Bench for spike_aer_encoder: directed scenarios plus randomized traffic
// checked against a queue-based reference model.
module tb_spike_aer_encoder;

    localparam int NN = 16;
    localparam int FD = 8;

    logic        clk;
    logic        rst_n;
    logic        enable;
    logic [15:0] spike_in;
    logic        timestep_tick;
    logic        clear_stats;
    logic        aer_ready;

    logic        aer_valid;
    logic [3:0]  aer_neuron_id;
    logic [15:0] aer_timestamp;
    logic [3:0]  fifo_count;
    logic [15:0] dropped_count;
    logic        overflow;

    logic        w4_valid;
    logic [3:0]  w4_id;
    logic [3:0]  w4_ts;
    logic [3:0]  w4_count;
    logic [15:0] w4_drop;
    logic        w4_ovf;

    int n_cmp;
    int n_err;

    spike_aer_encoder dut (
        .clk           (clk),
        .rst_n         (rst_n),
        .enable        (enable),
        .spike_in      (spike_in),
        .timestep_tick (timestep_tick),
        .clear_stats   (clear_stats),
        .aer_valid     (aer_valid),
        .aer_ready     (aer_ready),
        .aer_neuron_id (aer_neuron_id),
        .aer_timestamp (aer_timestamp),
        .fifo_count    (fifo_count),
        .dropped_count (dropped_count),
        .overflow      (overflow)
    );

    spike_aer_encoder #(.TIMESTAMP_WIDTH(4)) dut_w4 (
        .clk           (clk),
        .rst_n         (rst_n),
        .enable        (enable),
        .spike_in      (spike_in),
        .timestep_tick (timestep_tick),
        .clear_stats   (clear_stats),
        .aer_valid     (w4_valid),
        .aer_ready     (aer_ready),
        .aer_neuron_id (w4_id),
        .aer_timestamp (w4_ts),
        .fifo_count    (w4_count),
        .dropped_count (w4_drop),
        .overflow      (w4_ovf)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Reference model: a queue of events, an array of pending flags and plain counters.
    typedef struct {
        int id;
        int ts;
    } ev_t;

    ev_t m_q[$];
    bit  m_pend[NN];
    int  m_ptr;
    int  m_ts;
    int  m_drop;
    bit  m_ovf;

    task automatic model_reset();
        m_q.delete();
        for (int i = 0; i < NN; i++) m_pend[i] = 1'b0;
        m_ptr  = 0;
        m_ts   = 0;
        m_drop = 0;
        m_ovf  = 1'b0;
    endtask

    // Apply one clock edge worth of behaviour using the inputs held during that cycle.
    task automatic model_step();
        int g;
        int nd;
        bit full;
        if (!rst_n) begin
            model_reset();
            return;
        end
        full = (m_q.size() == FD);
        g = -1;
        if (enable && !full) begin
            for (int o = 0; o < NN; o++) begin
                int c;
                c = (m_ptr + o) % NN;
                if (g < 0 && m_pend[c]) g = c;
            end
        end
        nd = 0;
        if (enable) begin
            for (int i = 0; i < NN; i++)
                if (spike_in[i] && m_pend[i] && i != g) nd++;
        end
        if (m_q.size() != 0 && aer_ready) void'(m_q.pop_front());
        if (g >= 0) begin
            m_q.push_back('{g, m_ts});
            m_ptr = (g + 1) % NN;
            m_pend[g] = 1'b0;
        end
        if (enable) begin
            for (int i = 0; i < NN; i++)
                if (spike_in[i]) m_pend[i] = 1'b1;
        end
        if (clear_stats) begin
            m_drop = 0;
            m_ovf  = 1'b0;
        end else if (nd > 0) begin
            m_drop = (m_drop + nd > 65535) ? 65535 : m_drop + nd;
            m_ovf  = 1'b1;
        end
        if (enable && timestep_tick) m_ts = (m_ts + 1) % 65536;
    endtask

    // Advance one clock; returns at the falling edge with the model updated.
    task automatic cyc();
        @(negedge clk);
        model_step();
    endtask

    task automatic do_reset();
        rst_n         = 1'b0;
        enable        = 1'b0;
        spike_in      = '0;
        timestep_tick = 1'b0;
        clear_stats   = 1'b0;
        aer_ready     = 1'b0;
        cyc();
        cyc();
        rst_n = 1'b1;
    endtask

    task automatic test_reset();
        do_reset();
        enable   = 1'b1;
        spike_in = 16'h00F0;
        cyc();
        cyc();
        spike_in = '0;
        rst_n    = 1'b0;
        #1;
        n_cmp++; if (aer_valid !== 1'b0) begin n_err++; $display("FAIL reset_valid: got %b want 0", aer_valid); end
        n_cmp++; if (aer_neuron_id !== 4'd0) begin n_err++; $display("FAIL reset_id: got %0d want 0", aer_neuron_id); end
        n_cmp++; if (aer_timestamp !== 16'd0) begin n_err++; $display("FAIL reset_ts: got %0d want 0", aer_timestamp); end
        n_cmp++; if (fifo_count !== 4'd0) begin n_err++; $display("FAIL reset_count: got %0d want 0", fifo_count); end
        n_cmp++; if (dropped_count !== 16'd0) begin n_err++; $display("FAIL reset_dropped: got %0d want 0", dropped_count); end
        n_cmp++; if (overflow !== 1'b0) begin n_err++; $display("FAIL reset_overflow: got %b want 0", overflow); end
        cyc();
        rst_n = 1'b1;
        cyc();
        n_cmp++; if (aer_valid !== 1'b0) begin n_err++; $display("FAIL reset_release_valid: got %b want 0", aer_valid); end
    endtask

    task automatic test_single_spike();
        do_reset();
        enable    = 1'b1;
        aer_ready = 1'b1;
        spike_in  = 16'h0008;
        cyc();
        spike_in = '0;
        n_cmp++; if (aer_valid !== 1'b0) begin n_err++; $display("FAIL single_early_valid: got %b want 0", aer_valid); end
        cyc();
        n_cmp++; if (aer_valid !== 1'b1) begin n_err++; $display("FAIL single_valid: got %b want 1", aer_valid); end
        n_cmp++; if (aer_neuron_id !== 4'd3) begin n_err++; $display("FAIL single_id: got %0d want 3", aer_neuron_id); end
        n_cmp++; if (aer_timestamp !== 16'd0) begin n_err++; $display("FAIL single_ts: got %0d want 0", aer_timestamp); end
        n_cmp++; if (fifo_count !== 4'd1) begin n_err++; $display("FAIL single_count: got %0d want 1", fifo_count); end
        cyc();
        n_cmp++; if (aer_valid !== 1'b0) begin n_err++; $display("FAIL single_drain_valid: got %b want 0", aer_valid); end
        n_cmp++; if (fifo_count !== 4'd0) begin n_err++; $display("FAIL single_drain_count: got %0d want 0", fifo_count); end
    endtask

    task automatic test_burst_fairness();
        do_reset();
        enable    = 1'b1;
        aer_ready = 1'b1;
        spike_in  = 16'hFFFF;
        cyc();
        spike_in = '0;
        for (int k = 0; k < 16; k++) begin
            cyc();
            n_cmp++;
            if (aer_valid !== 1'b1 || aer_neuron_id !== 4'(k)) begin
                n_err++;
                $display("FAIL burst_id[%0d]: got valid=%b id=%0d want valid=1 id=%0d", k, aer_valid, aer_neuron_id, k);
            end
        end
        cyc();
        n_cmp++; if (fifo_count !== 4'd0) begin n_err++; $display("FAIL burst_count: got %0d want 0", fifo_count); end
        n_cmp++; if (dropped_count !== 16'd0) begin n_err++; $display("FAIL burst_dropped: got %0d want 0", dropped_count); end
        n_cmp++; if (overflow !== 1'b0) begin n_err++; $display("FAIL burst_overflow: got %b want 0", overflow); end
    endtask

    task automatic test_backpressure();
        int got;
        do_reset();
        enable    = 1'b1;
        aer_ready = 1'b0;
        spike_in  = 16'h03FF;
        cyc();
        spike_in = '0;
        repeat (12) cyc();
        n_cmp++; if (fifo_count !== 4'd8) begin n_err++; $display("FAIL bp_full_count: got %0d want 8", fifo_count); end
        n_cmp++; if (aer_neuron_id !== 4'd0) begin n_err++; $display("FAIL bp_head: got %0d want 0", aer_neuron_id); end
        cyc();
        n_cmp++; if (aer_valid !== 1'b1 || aer_neuron_id !== 4'd0) begin n_err++; $display("FAIL bp_stable: got valid=%b id=%0d want valid=1 id=0", aer_valid, aer_neuron_id); end
        aer_ready = 1'b1;
        got = 0;
        for (int c = 0; c < 40 && got < 10; c++) begin
            if (aer_valid) begin
                n_cmp++;
                if (aer_neuron_id !== 4'(got)) begin n_err++; $display("FAIL bp_order[%0d]: got %0d want %0d", got, aer_neuron_id, got); end
                got++;
            end
            cyc();
        end
        n_cmp++; if (got != 10) begin n_err++; $display("FAIL bp_event_total: got %0d want 10", got); end
        n_cmp++; if (fifo_count !== 4'd0) begin n_err++; $display("FAIL bp_drain_count: got %0d want 0", fifo_count); end
        n_cmp++; if (dropped_count !== 16'd0) begin n_err++; $display("FAIL bp_dropped: got %0d want 0", dropped_count); end
    endtask

    task automatic test_coalescing();
        do_reset();
        enable    = 1'b1;
        aer_ready = 1'b0;
        spike_in  = 16'h00FF;
        cyc();
        spike_in = '0;
        repeat (10) cyc();
        spike_in = 16'h1000;
        cyc();
        spike_in = '0;
        cyc();
        cyc();
        n_cmp++; if (overflow !== 1'b0) begin n_err++; $display("FAIL coal_first_pulse_ovf: got %b want 0", overflow); end
        spike_in = 16'h1000;
        cyc();
        spike_in = '0;
        n_cmp++; if (dropped_count !== 16'd1) begin n_err++; $display("FAIL coal_dropped: got %0d want 1", dropped_count); end
        n_cmp++; if (overflow !== 1'b1) begin n_err++; $display("FAIL coal_overflow: got %b want 1", overflow); end
        clear_stats = 1'b1;
        cyc();
        clear_stats = 1'b0;
        n_cmp++; if (dropped_count !== 16'd0) begin n_err++; $display("FAIL coal_clear_dropped: got %0d want 0", dropped_count); end
        n_cmp++; if (overflow !== 1'b0) begin n_err++; $display("FAIL coal_clear_overflow: got %b want 0", overflow); end
    endtask

    task automatic test_timestamp();
        do_reset();
        enable    = 1'b1;
        aer_ready = 1'b1;
        repeat (5) begin
            timestep_tick = 1'b1;
            cyc();
            timestep_tick = 1'b0;
            cyc();
        end
        spike_in = 16'h0001;
        cyc();
        spike_in      = '0;
        timestep_tick = 1'b1;
        cyc();
        timestep_tick = 1'b0;
        n_cmp++; if (aer_neuron_id !== 4'd0 || aer_timestamp !== 16'd5) begin n_err++; $display("FAIL ts_pretick: got id=%0d ts=%0d want id=0 ts=5", aer_neuron_id, aer_timestamp); end
        cyc();
        spike_in = 16'h0002;
        cyc();
        spike_in = '0;
        cyc();
        n_cmp++; if (aer_neuron_id !== 4'd1 || aer_timestamp !== 16'd6) begin n_err++; $display("FAIL ts_after_tick: got id=%0d ts=%0d want id=1 ts=6", aer_neuron_id, aer_timestamp); end

        do_reset();
        enable    = 1'b1;
        aer_ready = 1'b1;
        timestep_tick = 1'b1;
        repeat (16) cyc();
        timestep_tick = 1'b0;
        spike_in = 16'h0004;
        cyc();
        spike_in = '0;
        cyc();
        n_cmp++; if (aer_valid !== 1'b1 || aer_timestamp !== 16'd16) begin n_err++; $display("FAIL ts_16bit: got valid=%b ts=%0d want valid=1 ts=16", aer_valid, aer_timestamp); end
        n_cmp++; if (w4_valid !== 1'b1 || w4_id !== 4'd2 || w4_ts !== 4'd0) begin n_err++; $display("FAIL ts_wrap_w4: got valid=%b id=%0d ts=%0d want valid=1 id=2 ts=0", w4_valid, w4_id, w4_ts); end
    endtask

    task automatic test_reset_mid_stream();
        do_reset();
        enable    = 1'b1;
        aer_ready = 1'b0;
        spike_in  = 16'h000F;
        cyc();
        spike_in = '0;
        repeat (6) cyc();
        n_cmp++; if (fifo_count !== 4'd4 || aer_valid !== 1'b1) begin n_err++; $display("FAIL mid_queued: got count=%0d valid=%b want count=4 valid=1", fifo_count, aer_valid); end
        #2;
        rst_n = 1'b0;
        #1;
        n_cmp++; if (aer_valid !== 1'b0) begin n_err++; $display("FAIL mid_async_valid: got %b want 0", aer_valid); end
        n_cmp++; if (fifo_count !== 4'd0) begin n_err++; $display("FAIL mid_async_count: got %0d want 0", fifo_count); end
        cyc();
        rst_n     = 1'b1;
        aer_ready = 1'b1;
        repeat (6) begin
            cyc();
            n_cmp++; if (aer_valid !== 1'b0) begin n_err++; $display("FAIL mid_stale_event: got valid=%b id=%0d want valid=0", aer_valid, aer_neuron_id); end
        end
    endtask

    task automatic test_random_traffic();
        do_reset();
        for (int c = 0; c < 800; c++) begin
            enable        = ($urandom_range(0, 9) != 0);
            aer_ready     = ($urandom_range(0, 9) < 5);
            timestep_tick = ($urandom_range(0, 4) == 0);
            clear_stats   = ($urandom_range(0, 39) == 0);
            for (int i = 0; i < NN; i++) spike_in[i] = ($urandom_range(0, 11) == 0);
            cyc();
            n_cmp++; if (aer_valid !== (m_q.size() != 0)) begin n_err++; $display("FAIL rnd_valid@%0d: got %b want %b", c, aer_valid, m_q.size() != 0); end
            n_cmp++; if (fifo_count !== 4'(m_q.size())) begin n_err++; $display("FAIL rnd_count@%0d: got %0d want %0d", c, fifo_count, m_q.size()); end
            n_cmp++; if (dropped_count !== 16'(m_drop)) begin n_err++; $display("FAIL rnd_dropped@%0d: got %0d want %0d", c, dropped_count, m_drop); end
            n_cmp++; if (overflow !== m_ovf) begin n_err++; $display("FAIL rnd_overflow@%0d: got %b want %b", c, overflow, m_ovf); end
            n_cmp++; if (w4_count !== 4'(m_q.size()) || w4_drop !== 16'(m_drop) || w4_ovf !== m_ovf || w4_valid !== (m_q.size() != 0)) begin n_err++; $display("FAIL rnd_w4_status@%0d: got count=%0d drop=%0d ovf=%b valid=%b want count=%0d drop=%0d ovf=%b", c, w4_count, w4_drop, w4_ovf, w4_valid, m_q.size(), m_drop, m_ovf); end
            if (m_q.size() != 0) begin
                n_cmp++; if (aer_neuron_id !== 4'(m_q[0].id) || aer_timestamp !== 16'(m_q[0].ts)) begin n_err++; $display("FAIL rnd_head@%0d: got id=%0d ts=%0d want id=%0d ts=%0d", c, aer_neuron_id, aer_timestamp, m_q[0].id, m_q[0].ts); end
                n_cmp++; if (w4_id !== 4'(m_q[0].id) || w4_ts !== 4'(m_q[0].ts % 16)) begin n_err++; $display("FAIL rnd_w4_head@%0d: got id=%0d ts=%0d want id=%0d ts=%0d", c, w4_id, w4_ts, m_q[0].id, m_q[0].ts % 16); end
            end else begin
                n_cmp++; if (aer_neuron_id !== 4'd0 || aer_timestamp !== 16'd0) begin n_err++; $display("FAIL rnd_empty_fields@%0d: got id=%0d ts=%0d want 0 0", c, aer_neuron_id, aer_timestamp); end
            end
        end
    endtask

    initial begin
        n_cmp         = 0;
        n_err         = 0;
        rst_n         = 1'b1;
        enable        = 1'b0;
        spike_in      = '0;
        timestep_tick = 1'b0;
        clear_stats   = 1'b0;
        aer_ready     = 1'b0;
        model_reset();
        #2;
        test_reset();
        test_single_spike();
        test_burst_fairness();
        test_backpressure();
        test_coalescing();
        test_timestamp();
        test_reset_mid_stream();
        test_random_traffic();
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule : tb_spike_aer_encoder
